gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe: RTL



---
 rtl/gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe.sv
// Pipelined N-operand AND/NAND reducer: a tree of 3-input AND levels, one register per level,
// with a valid/ready handshake whose ready chain runs combinationally from OUT_READY.
module gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4,
    localparam int unsigned L = (N <= 3) ? 1 : (N <= 9) ? 2 : 3,
    localparam int unsigned OccW = $clog2(L + 1)
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic [N*W-1:0]    A,
    input  logic              INV,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [W-1:0]      Z,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [OccW-1:0]   OCC
);
    localparam int unsigned P = 3 ** L;
    // All stage words packed back to back: stage 1 at the bottom, the final word on top.
    localparam int unsigned T = (P - 1) / 2;

    logic [P*W-1:0]  a_pad;
    logic [T*W-1:0]  tree_d, tree_q;
    logic [L:1]      v_d, v_q, inv_d, inv_q, load;
    logic [OccW-1:0] occ_d, occ_q;
    logic [W-1:0]    top;

    // Missing operands are all-ones so they never clear a result bit.
    always_comb begin
        a_pad = '1;
        a_pad[N*W-1:0] = A;
    end

    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int unsigned G   = 3 ** (L - s);
        localparam int unsigned Off = (P - 3 ** (L - s + 1)) / 2;

        logic             up_v;
        logic             up_inv;
        logic [3*G*W-1:0] din;
        logic [G*W-1:0]   red;

        if (s == 1) begin : g_src_port
            assign up_v   = IN_VALID;
            assign up_inv = INV;
            assign din    = a_pad;
        end else begin : g_src_stage
            localparam int unsigned OffUp = (P - 3 ** (L - s + 2)) / 2;
            assign up_v   = v_q[s-1];
            assign up_inv = inv_q[s-1];
            assign din    = tree_q[OffUp*W +: 3*G*W];
        end

        always_comb begin
            red = '0;
            for (int g = 0; g < G; g++) begin
                red[g*W +: W] = din[3*g*W +: W] & din[(3*g+1)*W +: W] & din[(3*g+2)*W +: W];
            end
        end

        // A stage can take new data if output drains or any stage from here down is empty.
        assign load[s]  = OUT_READY || !(&v_q[L:s]);
        assign v_d[s]   = load[s] ? up_v : v_q[s];
        assign inv_d[s] = load[s] ? up_inv : inv_q[s];
        assign tree_d[Off*W +: G*W] = (load[s] && up_v) ? red : tree_q[Off*W +: G*W];
    end

    always_comb begin
        occ_d = '0;
        for (int s = 1; s <= L; s++) begin
            occ_d = occ_d + OccW'(v_d[s]);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            v_q    <= '0;
            inv_q  <= '0;
            tree_q <= '0;
            occ_q  <= '0;
        end else begin
            v_q    <= v_d;
            inv_q  <= inv_d;
            tree_q <= tree_d;
            occ_q  <= occ_d;
        end
    end

    assign top       = tree_q[(T-1)*W +: W];
    assign Z         = v_q[L] ? (inv_q[L] ? ~top : top) : '0;
    assign OUT_VALID = v_q[L];
    assign IN_READY  = load[1];
    assign OCC       = occ_q;

endmodule
